// File: rtl/wavelet_readout_ctrl_if.sv
// Output stream bundle of the wavelet readout controller: one coefficient per beat,
// valid/ready handshake, last marks the final word of the frame.
interface wavelet_readout_ctrl_if #(
    parameter int DATA_W = 16
) ();
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/wavelet_readout_ctrl.sv
// Reads the frozen coefficient RAM as even/odd word pairs once end_flag rises and
// streams the words in address order through a credit-limited FIFO.
module wavelet_readout_ctrl #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 16,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    end_flag,
    input  logic [DATA_W-1:0]       ram_q_a,
    input  logic [DATA_W-1:0]       ram_q_b,
    output logic [ADDR_W-1:0]       address_a_input,
    output logic [ADDR_W-1:0]       address_b_input,
    output logic                    busy,
    output logic                    done,
    wavelet_readout_ctrl_if.master  stream
);

    localparam int PAIR_W = ADDR_W - 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int IF_W   = $clog2(RD_LAT + 1);
    localparam int SUM_W  = CNT_W + IF_W + 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [PAIR_W-1:0] PAIR_MAX  = '1;
    localparam logic [ADDR_W-1:0] WORD_LAST = '1;
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [PTR_W-1:0]  PTR_PAIR  = PTR_W'(FIFO_DEPTH - 2);

    logic [1:0]        r_state;
    logic [PAIR_W-1:0] r_pair;
    logic [RD_LAT-1:0] r_vsr;
    logic [IF_W-1:0]   r_inflight;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_outIdx;
    logic              r_lastPopped;

    logic              w_abort;
    logic              w_credit;
    logic              w_issue;
    logic              w_ret;
    logic              w_valid;
    logic              w_pop;
    logic [PTR_W-1:0]  w_wptrOdd;
    logic [PTR_W-1:0]  w_wptrNext;
    logic [PTR_W-1:0]  w_rptrNext;

    assign w_abort  = ((r_state == S_READ) || (r_state == S_DRAIN)) && !end_flag;
    // Every pair still in the RAM pipeline already owns two FIFO slots.
    assign w_credit = (SUM_W'(r_count) + SUM_W'({r_inflight, 1'b0}) + SUM_W'(2))
                      <= SUM_W'(FIFO_DEPTH);
    assign w_issue  = (r_state == S_READ) && end_flag && w_credit;
    assign w_ret    = r_vsr[RD_LAT-1];
    assign w_valid  = (r_count != '0);
    assign w_pop    = w_valid && stream.out_ready;

    // Pairs are always written together, so the write pointer stays even.
    assign w_wptrOdd  = r_wptr + PTR_W'(1);
    assign w_wptrNext = (r_wptr == PTR_PAIR) ? '0 : r_wptr + PTR_W'(2);
    assign w_rptrNext = (r_rptr == PTR_LAST) ? '0 : r_rptr + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (w_ret) begin
            r_mem[r_wptr]    <= ram_q_a;
            r_mem[w_wptrOdd] <= ram_q_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_pair       <= '0;
            r_vsr        <= '0;
            r_inflight   <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_outIdx     <= '0;
            r_lastPopped <= 1'b0;
        end else if (w_abort) begin
            r_state      <= S_IDLE;
            r_pair       <= '0;
            r_vsr        <= '0;
            r_inflight   <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_outIdx     <= '0;
            r_lastPopped <= 1'b0;
        end else begin
            r_vsr <= (r_vsr << 1) | RD_LAT'(w_issue);

            case ({w_issue, w_ret})
                2'b10:   r_inflight <= r_inflight + IF_W'(1);
                2'b01:   r_inflight <= r_inflight - IF_W'(1);
                default: r_inflight <= r_inflight;
            endcase

            if (w_ret) begin
                r_wptr <= w_wptrNext;
            end
            r_count <= r_count + CNT_W'(w_ret ? 2 : 0) - CNT_W'(w_pop);

            if (w_pop) begin
                r_rptr   <= w_rptrNext;
                r_outIdx <= r_outIdx + ADDR_W'(1);
                if (r_outIdx == WORD_LAST) begin
                    r_lastPopped <= 1'b1;
                end
            end

            if (w_issue) begin
                r_pair <= r_pair + PAIR_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (end_flag) begin
                        r_state      <= S_READ;
                        r_pair       <= '0;
                        r_outIdx     <= '0;
                        r_lastPopped <= 1'b0;
                    end
                end
                S_READ: begin
                    if (w_issue && (r_pair == PAIR_MAX)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if ((r_inflight == '0) && (r_count == '0) && r_lastPopped) begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    if (!end_flag) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign address_a_input  = (r_state == S_READ) ? {r_pair, 1'b0} : '0;
    assign address_b_input  = (r_state == S_READ) ? {r_pair, 1'b1} : '0;
    assign busy             = (r_state == S_READ) || (r_state == S_DRAIN);
    assign done             = (r_state == S_DONE);
    assign stream.out_valid = w_valid;
    assign stream.out_data  = w_valid ? r_mem[r_rptr] : '0;
    assign stream.out_last  = w_valid && (r_outIdx == WORD_LAST);

endmodule

// File: tb/tb_wavelet_readout_ctrl.sv
// Directed bench for wavelet_readout_ctrl: a two-cycle RAM model returning q = address
// feeds the controller while a negedge monitor scores every popped word.
module tb_wavelet_readout_ctrl;

    localparam int ADDR_W      = 12;
    localparam int DATA_W      = 16;
    localparam int FRAME_WORDS = 4096;
    localparam int BUDGET      = 30000;

    logic              clk;
    logic              rst_n;
    logic              end_flag;
    logic [DATA_W-1:0] ram_q_a;
    logic [DATA_W-1:0] ram_q_b;
    logic [ADDR_W-1:0] address_a_input;
    logic [ADDR_W-1:0] address_b_input;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] addrADelay;
    logic [ADDR_W-1:0] addrBDelay;

    wavelet_readout_ctrl_if #(.DATA_W(DATA_W)) streamIf ();

    wavelet_readout_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2), .FIFO_DEPTH(8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .end_flag        (end_flag),
        .ram_q_a         (ram_q_a),
        .ram_q_b         (ram_q_b),
        .address_a_input (address_a_input),
        .address_b_input (address_b_input),
        .busy            (busy),
        .done            (done),
        .stream          (streamIf)
    );

    int checkCount = 0;
    int errorCount = 0;
    int popCount   = 0;
    int seqErr     = 0;
    int lastErr    = 0;
    int lastSeen   = 0;
    int monWord    = 0;
    int frameStart = 0;
    int seqBase    = 0;
    int lastBase   = 0;
    int seenBase   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model with a two-cycle read latency, data equal to the word address.
    always @(posedge clk) begin
        addrADelay <= address_a_input;
        addrBDelay <= address_b_input;
        ram_q_a    <= {4'b0000, addrADelay};
        ram_q_b    <= {4'b0000, addrBDelay};
    end

    // Score every accepted beat against its position in the current frame.
    always @(negedge clk) begin
        if (rst_n && streamIf.out_valid && streamIf.out_ready) begin
            monWord = popCount - frameStart;
            if (streamIf.out_data !== monWord[DATA_W-1:0]) seqErr = seqErr + 1;
            if (streamIf.out_last !== (monWord == FRAME_WORDS - 1)) lastErr = lastErr + 1;
            if (streamIf.out_last) lastSeen = lastSeen + 1;
            popCount = popCount + 1;
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount = checkCount + 1;
        if (observed != expected) begin
            errorCount = errorCount + 1;
            $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic endLevel, input logic readyLevel);
        @(posedge clk);
        #1;
        end_flag           = endLevel;
        streamIf.out_ready = readyLevel;
    endtask

    task automatic startFrame();
        frameStart = popCount;
        seqBase    = seqErr;
        lastBase   = lastErr;
        seenBase   = lastSeen;
    endtask

    task automatic waitDone(input string tag, input bit randomReady);
        for (int cyc = 0; cyc < BUDGET && !done; cyc++) begin
            @(posedge clk);
            #1;
            if (randomReady) streamIf.out_ready = 1'($urandom_range(0, 1));
        end
        checkOutput(tag, 32'(done), 1);
        streamIf.out_ready = 1'b1;
    endtask

    task automatic checkFrame(input string tag);
        checkOutput({tag, "Words"}, popCount - frameStart, FRAME_WORDS);
        checkOutput({tag, "Order"}, seqErr - seqBase, 0);
        checkOutput({tag, "LastMisplaced"}, lastErr - lastBase, 0);
        checkOutput({tag, "LastCount"}, lastSeen - seenBase, 1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "Valid"}, 32'(streamIf.out_valid), 0);
        checkOutput({tag, "Data"}, 32'(streamIf.out_data), 0);
        checkOutput({tag, "Last"}, 32'(streamIf.out_last), 0);
        checkOutput({tag, "Busy"}, 32'(busy), 0);
        checkOutput({tag, "Done"}, 32'(done), 0);
        checkOutput({tag, "AddrA"}, 32'(address_a_input), 0);
        checkOutput({tag, "AddrB"}, 32'(address_b_input), 0);
    endtask

    initial begin
        int n;
        int busyAt;
        int validAt;
        bit found;
        logic [ADDR_W-1:0] addrMid;

        rst_n              = 1'b0;
        end_flag           = 1'b0;
        streamIf.out_ready = 1'b1;
        #12;
        checkAllZero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] frame with sink always ready");
        startFrame();
        applyStimulus(1'b1, 1'b1);
        n = 0; busyAt = -1; validAt = -1;
        while (n < 20 && validAt < 0) begin
            @(negedge clk);
            n = n + 1;
            if (busy && busyAt < 0) busyAt = n;
            if (streamIf.out_valid && validAt < 0) validAt = n;
        end
        checkOutput("firstValidLatency", validAt - busyAt, 3);
        waitDone("frame1Done", 1'b0);
        checkFrame("frame1");
        checkOutput("frame1BusyAfter", 32'(busy), 0);
        checkOutput("frame1ValidAfter", 32'(streamIf.out_valid), 0);

        $display("[TB] hold end_flag high in DONE");
        repeat (50) @(posedge clk);
        #1;
        checkOutput("holdDone", 32'(done), 1);
        checkOutput("holdBusy", 32'(busy), 0);
        checkOutput("holdNoNewWords", popCount - frameStart, FRAME_WORDS);

        $display("[TB] frame with 20-cycle sink stall at word 100");
        applyStimulus(1'b0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("doneClearsOnLow", 32'(done), 0);
        startFrame();
        applyStimulus(1'b1, 1'b1);
        for (int cyc = 0; cyc < BUDGET && (popCount - frameStart) < 100; cyc++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("reachedWord100", popCount - frameStart, 100);
        streamIf.out_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        addrMid = address_a_input;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("stallAddrFrozen", 32'(address_a_input), 32'(addrMid));
        checkOutput("stallValid", 32'(streamIf.out_valid), 1);
        checkOutput("stallHeadData", 32'(streamIf.out_data), 100);
        checkOutput("stallNoPops", popCount - frameStart, 100);
        streamIf.out_ready = 1'b1;
        waitDone("stallFrameDone", 1'b0);
        checkFrame("stallFrame");

        $display("[TB] frame with random sink ready");
        applyStimulus(1'b0, 1'b1);
        @(posedge clk);
        startFrame();
        applyStimulus(1'b1, 1'b1);
        waitDone("randomFrameDone", 1'b1);
        checkFrame("randomFrame");

        $display("[TB] abort at pair 500");
        applyStimulus(1'b0, 1'b1);
        @(posedge clk);
        startFrame();
        applyStimulus(1'b1, 1'b1);
        found = 1'b0;
        for (int cyc = 0; cyc < BUDGET && !found; cyc++) begin
            @(posedge clk);
            #1;
            if (address_a_input >= 12'd1000) found = 1'b1;
        end
        checkOutput("reachedPair500", 32'(found), 1);
        applyStimulus(1'b0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("abortValid", 32'(streamIf.out_valid), 0);
        checkOutput("abortBusy", 32'(busy), 0);
        checkOutput("abortDone", 32'(done), 0);
        startFrame();
        applyStimulus(1'b1, 1'b1);
        waitDone("abortRestartDone", 1'b0);
        checkFrame("abortRestart");

        $display("[TB] asynchronous reset during DRAIN");
        applyStimulus(1'b0, 1'b1);
        @(posedge clk);
        startFrame();
        applyStimulus(1'b1, 1'b1);
        found = 1'b0;
        for (int cyc = 0; cyc < BUDGET && !found; cyc++) begin
            @(posedge clk);
            #1;
            if (busy && address_a_input == '0 && (popCount - frameStart) > 4000) found = 1'b1;
        end
        checkOutput("reachedDrain", 32'(found), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("midDrainReset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        startFrame();
        waitDone("resetRestartDone", 1'b0);
        checkFrame("resetRestart");

        $display("[TB] CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/wavelet_readout_ctrl.md
Name: wavelet_readout_ctrl

Overview:
Sequences readout of the finished 64x64 coefficient array from the result RAM once the wavelet controller raises end_flag. It drives the RAM's two read addresses, even word on port A and odd word on port B. It tracks the fixed RAM read latency and buffers returned pairs in a small credit-controlled FIFO. The FIFO feeds a one-word-per-cycle valid/ready stream toward the host interface, with a last marker on the final word.

Parameters:
ADDR_W, 12, RAM word-address width; frame size is 2^ADDR_W words (4096).
DATA_W, 16, coefficient width.
RD_LAT, 2, cycles from address presented to ram_q_a/ram_q_b valid.
FIFO_DEPTH, 8, output FIFO entries in words; must be even and >= 2*RD_LAT+2.

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
end_flag  input  1  level from wavelet controller; high = result RAM frozen and readable
ram_q_a  input  DATA_W  RAM port A read data
ram_q_b  input  DATA_W  RAM port B read data
address_a_input  output  ADDR_W  port A read address (even words)
address_b_input  output  ADDR_W  port B read address (odd words)
out_data  output  DATA_W  stream data
out_valid  output  1  stream valid
out_ready  input  1  stream ready from sink
out_last  output  1  high with word 2^ADDR_W-1
busy  output  1  high in READ or DRAIN
done  output  1  high in DONE

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; FIFO empty; in-flight pipeline cleared; pair counter 0.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE -> READ on the cycle end_flag is sampled high. An end_flag already high when reset releases also starts the sequence.
- READ:
  - Pair index p runs 0..2^(ADDR_W-1)-1.
  - address_a_input = 2p; address_b_input = 2p+1.
  - Issue condition: FIFO_DEPTH - occupancy - 2*inflight >= 2, where inflight = pairs issued but not yet returned.
  - On issue: p increments and a 1 enters an RD_LAT-deep valid shift register. When not issuing, a 0 enters.
  - Addresses hold their last value while stalled.
  - After issuing p = max, go to DRAIN.
- Return: when the shift register output is 1, push ram_q_a then ram_q_b into the FIFO in that order. The FIFO accepts 2 writes and 1 read in the same cycle; the credit rule guarantees no overflow.
- Output:
  - out_valid = FIFO not empty; out_data = FIFO head.
  - A word pops when out_valid && out_ready.
  - Words emerge strictly in address order 0,1,...,4095.
  - out_last is asserted with word 4095 only.
- DRAIN: no issues; address outputs return to 0. DRAIN -> DONE when inflight = 0, the FIFO is empty, and the last word has popped.
- DONE: done = 1, busy = 0. DONE -> IDLE when end_flag is sampled low. A new frame requires end_flag to go low and then high again.
- Abort: end_flag sampled low in READ or DRAIN causes, on the next edge:
  - FIFO flushed, shift register cleared, p = 0
  - out_valid = 0
  - return to IDLE; done is not asserted.
- Sink stalls (out_ready low for any length): no loss and no duplication. Issuing stops once credit is exhausted.
- Simultaneous FIFO push and pop: occupancy changes by +1.
- Asynchronous reset mid-frame: immediate return to reset values, with no partial output afterwards.
- Counter widths: p is ADDR_W-1 bits. There is no wrap inside a frame, because the terminal p forces the DRAIN transition.

Test Plan:
- Frame with out_ready tied high and RAM model q = address: raise end_flag -> words 0..4095 in order; out_last only on 4095; first out_valid 3 cycles after READ entry (RD_LAT + 1); done high after the last pop.
- Sink backpressure, out_ready low for 20 cycles at word 100: occupancy reaches 8 and never exceeds it; address issuing stalls; resumes with word 100 exactly; total output 4096 words with no gaps or repeats.
- Random out_ready (50%): output sequence equals 0..4095; at most 2048 address pairs issued, each exactly once.
- end_flag dropped at pair 500 -> next cycle out_valid = 0, busy = 0, done = 0. Raising end_flag again -> restarts from word 0.
- rst_n pulsed low mid-DRAIN -> all outputs 0 asynchronously. With end_flag still high at release, a complete new frame starts from word 0.
- DONE with end_flag held high for 50 cycles -> no new frame. Drop end_flag, then raise it -> second full frame identical to the first.
